// File: rtl/alu_seq_unit.sv
// rtl/alu_seq_unit.sv - multicycle RV32I execute unit with iterative shifter
//
// Decodes alu_op/funct3/op_5/funct7 into the RV32I ALU operation set and
// executes it behind a valid/ready handshake. Non-shift ops finish on the
// accept edge; shifts iterate SHIFT_STEP positions per cycle.
//
// Optional feature macro: ALU_MUL_EN
//   defined   - R-type funct7_0 with funct3=000 is MUL (low XLEN bits),
//               computed by shift-add, one multiplier bit per cycle
//   undefined - no multiplier; every R-type funct7_0 op is illegal
//
// Ports:
//   clk       clock, all state on rising edge
//   rst_n     asynchronous active-low reset
//   in_valid  operands/controls valid
//   in_ready  unit can accept (IDLE only)
//   alu_op    00 add, 01 sub, 10 decode funct fields, 11 reserved
//   funct3    instruction funct3
//   op_5      opcode bit 5 (1 = R-type)
//   funct7_5  funct7 bit 5
//   funct7_0  funct7 bit 0 (M-extension select)
//   src_a     operand A
//   src_b     operand B
//   out_valid result valid
//   out_ready consumer accepts result
//   result    registered result
//   zero      result == 0
//   illegal   registered with result; op was undecodable

module alu_seq_unit #(
   parameter int XLEN       = 32,
   parameter int SHIFT_STEP = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [1:0]      alu_op,
   input  logic [2:0]      funct3,
   input  logic            op_5,
   input  logic            funct7_5,
   input  logic            funct7_0,
   input  logic [XLEN-1:0] src_a,
   input  logic [XLEN-1:0] src_b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            illegal
);

   localparam int SHW = $clog2(XLEN);
   localparam logic [SHW:0] STEP_V = (SHW+1)'(SHIFT_STEP);

`ifdef ALU_MUL_EN
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_MUL, S_DONE} state_t;
`else
   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;
`endif

   typedef enum logic [3:0] {
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR,
      OP_SRL, OP_SRA, OP_OR, OP_AND, OP_MUL, OP_ILL
   } op_t;

   state_t          state;
   op_t             dec_op;
   op_t             op_q;
   logic [XLEN-1:0] alu_res;
   logic [XLEN-1:0] work;      // shift accumulator, or product under MUL
   logic [SHW-1:0]  rem;       // shift positions left, or MUL bits left - 1
   logic [SHW-1:0]  shamt_in;
   logic [SHW:0]    step_amt;
   logic [SHW-1:0]  rem_next;
   logic [XLEN-1:0] shifted;

`ifdef ALU_MUL_EN
   logic [XLEN-1:0] mul_a;
   logic [XLEN-1:0] mul_b;
   logic [XLEN-1:0] prod_next;

   assign prod_next = work + (mul_b[0] ? mul_a : '0);
`endif

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign zero      = (result == '0);
   assign shamt_in  = src_b[SHW-1:0];

   always_comb begin
      dec_op = OP_ILL;
      case (alu_op)
         2'b00: dec_op = OP_ADD;
         2'b01: dec_op = OP_SUB;
         2'b10: begin
            if (op_5 && funct7_0) begin
`ifdef ALU_MUL_EN
               if (funct3 == 3'b000) dec_op = OP_MUL;
`endif
            end else begin
               case (funct3)
                  3'b000: dec_op = (op_5 && funct7_5) ? OP_SUB : OP_ADD;
                  3'b001: dec_op = OP_SLL;
                  3'b010: dec_op = OP_SLT;
                  3'b011: dec_op = OP_SLTU;
                  3'b100: dec_op = OP_XOR;
                  3'b101: dec_op = funct7_5 ? OP_SRA : OP_SRL;
                  3'b110: dec_op = OP_OR;
                  default: dec_op = OP_AND;
               endcase
            end
         end
         default: dec_op = OP_ILL;
      endcase
   end

   // Single-cycle ops; OP_ILL falls through to zero.
   always_comb begin
      alu_res = '0;
      case (dec_op)
         OP_ADD:  alu_res = src_a + src_b;
         OP_SUB:  alu_res = src_a - src_b;
         OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(src_a) < $signed(src_b)};
         OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
         OP_XOR:  alu_res = src_a ^ src_b;
         OP_OR:   alu_res = src_a | src_b;
         OP_AND:  alu_res = src_a & src_b;
         default: alu_res = '0;
      endcase
   end

   // One shift step: min(SHIFT_STEP, remaining). rem < XLEN, so the step
   // always fits in SHW bits once clamped to rem.
   always_comb begin
      step_amt = ({1'b0, rem} < STEP_V) ? {1'b0, rem} : STEP_V;
      rem_next = rem - step_amt[SHW-1:0];
      case (op_q)
         OP_SLL:  shifted = work << step_amt;
         OP_SRL:  shifted = work >> step_amt;
         default: shifted = $signed(work) >>> step_amt;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         op_q    <= OP_ADD;
         work    <= '0;
         rem     <= '0;
         result  <= '0;
         illegal <= 1'b0;
`ifdef ALU_MUL_EN
         mul_a   <= '0;
         mul_b   <= '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  op_q    <= dec_op;
                  illegal <= (dec_op == OP_ILL);
                  case (dec_op)
                     OP_SLL, OP_SRL, OP_SRA: begin
                        if (shamt_in == '0) begin
                           result <= src_a;
                           state  <= S_DONE;
                        end else begin
                           work  <= src_a;
                           rem   <= shamt_in;
                           state <= S_SHIFT;
                        end
                     end
`ifdef ALU_MUL_EN
                     OP_MUL: begin
                        work  <= '0;
                        mul_a <= src_a;
                        mul_b <= src_b;
                        rem   <= SHW'(XLEN-1);
                        state <= S_MUL;
                     end
`endif
                     default: begin
                        result <= alu_res;
                        state  <= S_DONE;
                     end
                  endcase
               end
            end
            S_SHIFT: begin
               work <= shifted;
               rem  <= rem_next;
               if (rem_next == '0) begin
                  result <= shifted;
                  state  <= S_DONE;
               end
            end
`ifdef ALU_MUL_EN
            S_MUL: begin
               work  <= prod_next;
               mul_a <= mul_a << 1;
               mul_b <= mul_b >> 1;
               rem   <= rem - SHW'(1);
               if (rem == '0) begin
                  result <= prod_next;
                  state  <= S_DONE;
               end
            end
`endif
            S_DONE: begin
               if (out_ready) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule
